// File: rtl/rename_regfile_pkg.sv
// Shared configuration for the rename register file: default sizes, zero
// constants and the recovery-mode decode used by the top level.
package rename_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int TAGW_DEF  = 4;
  localparam int NCMT_DEF  = 2;
  localparam int NCKPT_DEF = 4;

  localparam int   ZERO_REG_ADDR = 0;
  localparam int   ZERO_DATA     = 0;
  localparam logic TRUE          = 1'b1;
  localparam logic FALSE         = 1'b0;

  typedef enum logic [1:0] {
    RECOVER_NONE,
    RECOVER_RESTORE,
    RECOVER_CLEAR
  } recover_e;

  // A misbranch restores only from a slot that actually holds a snapshot.
  function automatic recover_e recover_mode(input logic misbranch,
                                            input logic restore_en,
                                            input logic slot_valid);
    if (!misbranch)
      return RECOVER_NONE;
    if (restore_en && slot_valid)
      return RECOVER_RESTORE;
    return RECOVER_CLEAR;
  endfunction

endpackage

// File: rtl/rename_ckpt_slot.sv
// One rename-state snapshot: busy vector and tag array, kept coherent with
// commits so a later restore sees producers that finished in the meantime.
module rename_ckpt_slot
  import rename_regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int TAGW = TAGW_DEF,
  parameter int NCMT = NCMT_DEF,
  localparam int RAW = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       save,
  input  logic [NREG-1:0]            save_busy,
  input  logic [NREG-1:0][TAGW-1:0]  save_rob,
  input  logic                       invalidate,
  input  logic [NCMT-1:0]            cmt_valid,
  input  logic [NCMT*RAW-1:0]        cmt_reg,
  input  logic [NCMT*TAGW-1:0]       cmt_rob_num,
  output logic                       valid,
  output logic [NREG-1:0]            busy,
  output logic [NREG-1:0][TAGW-1:0]  rob_num
);

  logic                      valid_reg;
  logic [NREG-1:0]           busy_reg;
  logic [NREG-1:0]           busy_next;
  logic [NREG-1:0][TAGW-1:0] rob_reg;

  always_comb begin
    busy_next = busy_reg;
    for (int k = 0; k < NCMT; k++) begin
      if (cmt_valid[k] &&
          rob_reg[cmt_reg[k*RAW +: RAW]] == cmt_rob_num[k*TAGW +: TAGW])
        busy_next[cmt_reg[k*RAW +: RAW]] = FALSE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= FALSE;
      busy_reg  <= '0;
      rob_reg   <= '0;
    end else if (en) begin
      if (invalidate) begin
        valid_reg <= FALSE;
      end else if (save) begin
        // The saved image already contains this cycle's commit clears.
        valid_reg <= TRUE;
        busy_reg  <= save_busy;
        rob_reg   <= save_rob;
      end else if (valid_reg) begin
        busy_reg  <= busy_next;
      end
    end
  end

  assign valid   = valid_reg;
  assign busy    = busy_reg;
  assign rob_num = rob_reg;

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename busy/tag tracking, commit bypass
// and checkpoint-based misbranch recovery.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAGW  = TAGW_DEF,
  parameter int NCMT  = NCMT_DEF,
  parameter int NCKPT = NCKPT_DEF,
  localparam int RAW  = $clog2(NREG),
  localparam int CKW  = $clog2(NCKPT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [RAW-1:0]         rs1_addr,
  input  logic [RAW-1:0]         rs2_addr,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [TAGW-1:0]        rs1_rob_num,
  output logic [TAGW-1:0]        rs2_rob_num,
  input  logic                   needsetbusy,
  input  logic [RAW-1:0]         rd_addr,
  input  logic [TAGW-1:0]        rd_rob_num,
  input  logic [NCMT-1:0]        cmt_valid,
  input  logic [NCMT*RAW-1:0]    cmt_reg,
  input  logic [NCMT*XLEN-1:0]   cmt_data,
  input  logic [NCMT*TAGW-1:0]   cmt_rob_num,
  input  logic                   ckpt_save,
  input  logic [CKW-1:0]         ckpt_save_id,
  input  logic                   has_misbranch,
  input  logic                   ckpt_restore_en,
  input  logic [CKW-1:0]         ckpt_restore_id,
  output logic [NCKPT-1:0]       ckpt_valid
);

  localparam logic [RAW-1:0] ZERO_ADDR = RAW'(ZERO_REG_ADDR);

  logic [XLEN-1:0]           datas_reg [NREG];
  logic [NREG-1:0]           busy_reg;
  logic [NREG-1:0]           busy_next;
  logic [NREG-1:0][TAGW-1:0] rob_reg;
  logic [NREG-1:0][TAGW-1:0] rob_next;

  logic [RAW-1:0]  c_reg  [NCMT];
  logic [XLEN-1:0] c_data [NCMT];
  logic [TAGW-1:0] c_rob  [NCMT];
  logic [NCMT-1:0] c_live;

  logic [NCKPT-1:0]          slot_valid;
  logic [NREG-1:0]           slot_busy [NCKPT];
  logic [NREG-1:0][TAGW-1:0] slot_rob  [NCKPT];

  recover_e recover;

  genvar gi;

  generate
    for (gi = 0; gi < NCMT; gi++) begin : g_cmt
      assign c_reg[gi]  = cmt_reg[gi*RAW +: RAW];
      assign c_data[gi] = cmt_data[gi*XLEN +: XLEN];
      assign c_rob[gi]  = cmt_rob_num[gi*TAGW +: TAGW];
      assign c_live[gi] = cmt_valid[gi] && (c_reg[gi] != ZERO_ADDR);
    end
  endgenerate

  // Read ports: higher commit ports are visited last so they win the bypass.
  logic [RAW-1:0]  rd_sel  [2];
  logic [XLEN-1:0] rd_data [2];
  logic            rd_busy [2];
  logic [TAGW-1:0] rd_tag  [2];

  assign rd_sel[0] = rs1_addr;
  assign rd_sel[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = datas_reg[rd_sel[gi]];
        rd_busy[gi] = busy_reg[rd_sel[gi]];
        rd_tag[gi]  = rob_reg[rd_sel[gi]];
        for (int k = 0; k < NCMT; k++) begin
          if (c_live[k] && c_reg[k] == rd_sel[gi] &&
              c_rob[k] == rob_reg[rd_sel[gi]]) begin
            rd_data[gi] = c_data[k];
            rd_busy[gi] = FALSE;
          end
        end
        if (rd_sel[gi] == ZERO_ADDR) begin
          rd_data[gi] = XLEN'(ZERO_DATA);
          rd_busy[gi] = FALSE;
          rd_tag[gi]  = '0;
        end
      end
    end
  endgenerate

  assign rs1_data    = rd_data[0];
  assign rs2_data    = rd_data[1];
  assign rs1_busy    = rd_busy[0];
  assign rs2_busy    = rd_busy[1];
  assign rs1_rob_num = rd_tag[0];
  assign rs2_rob_num = rd_tag[1];

  assign recover = recover_mode(has_misbranch, ckpt_restore_en,
                                slot_valid[ckpt_restore_id]);

  // Next rename state: pick the base image, apply commit clears against the
  // base's own tags, then let a rename override.
  always_comb begin
    busy_next = busy_reg;
    rob_next  = rob_reg;
    case (recover)
      RECOVER_RESTORE: begin
        busy_next = slot_busy[ckpt_restore_id];
        rob_next  = slot_rob[ckpt_restore_id];
      end
      RECOVER_CLEAR: busy_next = '0;
      default: ;
    endcase
    for (int k = 0; k < NCMT; k++) begin
      if (c_live[k] && c_rob[k] == rob_next[c_reg[k]])
        busy_next[c_reg[k]] = FALSE;
    end
    if (recover == RECOVER_NONE && needsetbusy && rd_addr != ZERO_ADDR) begin
      busy_next[rd_addr] = TRUE;
      rob_next[rd_addr]  = rd_rob_num;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
      rob_reg  <= '0;
      for (int r = 0; r < NREG; r++)
        datas_reg[r] <= XLEN'(ZERO_DATA);
    end else if (rdy) begin
      busy_reg <= busy_next;
      rob_reg  <= rob_next;
      for (int k = 0; k < NCMT; k++) begin
        if (c_live[k])
          datas_reg[c_reg[k]] <= c_data[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NCKPT; gi++) begin : g_slot
      rename_ckpt_slot #(
        .NREG (NREG),
        .TAGW (TAGW),
        .NCMT (NCMT)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .en          (rdy),
        .save        (ckpt_save && !has_misbranch && ckpt_save_id == CKW'(gi)),
        .save_busy   (busy_next),
        .save_rob    (rob_next),
        .invalidate  (has_misbranch),
        .cmt_valid   (c_live),
        .cmt_reg     (cmt_reg),
        .cmt_rob_num (cmt_rob_num),
        .valid       (slot_valid[gi]),
        .busy        (slot_busy[gi]),
        .rob_num     (slot_rob[gi])
      );
    end
  endgenerate

  assign ckpt_valid = slot_valid;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed scenarios plus a randomized run checked against a behavioural
// model of the register file, its rename state and its checkpoints.
module tb_rename_regfile;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAGW  = 4;
  localparam int NCMT  = 2;
  localparam int NCKPT = 4;
  localparam int RAW   = $clog2(NREG);
  localparam int CKW   = $clog2(NCKPT);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy;
  logic [RAW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic rs1_busy, rs2_busy;
  logic [TAGW-1:0] rs1_rob_num, rs2_rob_num;
  logic needsetbusy;
  logic [RAW-1:0] rd_addr;
  logic [TAGW-1:0] rd_rob_num;
  logic [NCMT-1:0] cmt_valid;
  logic [NCMT*RAW-1:0] cmt_reg;
  logic [NCMT*XLEN-1:0] cmt_data;
  logic [NCMT*TAGW-1:0] cmt_rob_num;
  logic ckpt_save;
  logic [CKW-1:0] ckpt_save_id;
  logic has_misbranch;
  logic ckpt_restore_en;
  logic [CKW-1:0] ckpt_restore_id;
  logic [NCKPT-1:0] ckpt_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [XLEN-1:0] m_data [NREG];
  bit              m_busy [NREG];
  int              m_tag  [NREG];
  bit              m_ckv  [NCKPT];
  bit              m_ckb  [NCKPT][NREG];
  int              m_ckt  [NCKPT][NREG];

  rename_regfile #(
    .XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NCMT(NCMT), .NCKPT(NCKPT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob_num(rs1_rob_num), .rs2_rob_num(rs2_rob_num),
    .needsetbusy(needsetbusy), .rd_addr(rd_addr), .rd_rob_num(rd_rob_num),
    .cmt_valid(cmt_valid), .cmt_reg(cmt_reg), .cmt_data(cmt_data),
    .cmt_rob_num(cmt_rob_num),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .has_misbranch(has_misbranch), .ckpt_restore_en(ckpt_restore_en),
    .ckpt_restore_id(ckpt_restore_id), .ckpt_valid(ckpt_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_data[r] = '0; m_busy[r] = 0; m_tag[r] = 0;
    end
    for (int s = 0; s < NCKPT; s++) begin
      m_ckv[s] = 0;
      for (int r = 0; r < NREG; r++) begin
        m_ckb[s][r] = 0; m_ckt[s][r] = 0;
      end
    end
  endtask

  function automatic int c_r(input int k);
    return int'(cmt_reg[k*RAW +: RAW]);
  endfunction

  function automatic int c_t(input int k);
    return int'(cmt_rob_num[k*TAGW +: TAGW]);
  endfunction

  // What an issue read of register a should return this cycle.
  task automatic model_read(input int a, output logic [XLEN-1:0] d,
                            output bit b, output int t);
    d = m_data[a]; b = m_busy[a]; t = m_tag[a];
    for (int k = 0; k < NCMT; k++)
      if (cmt_valid[k] && c_r(k) == a && c_t(k) == m_tag[a]) begin
        d = cmt_data[k*XLEN +: XLEN]; b = 0;
      end
    if (a == 0) begin
      d = '0; b = 0; t = 0;
    end
  endtask

  // Clock-edge effect of the current inputs on the model.
  task automatic model_step();
    logic [XLEN-1:0] nd [NREG];
    bit nb [NREG];
    int nt [NREG];
    bit restore;
    int rid, sid;
    if (!rdy) return;
    nd = m_data;
    for (int k = 0; k < NCMT; k++)
      if (cmt_valid[k] && c_r(k) != 0) nd[c_r(k)] = cmt_data[k*XLEN +: XLEN];
    rid = int'(ckpt_restore_id);
    restore = has_misbranch && ckpt_restore_en && m_ckv[rid];
    for (int r = 0; r < NREG; r++) begin
      nb[r] = restore ? m_ckb[rid][r] : (has_misbranch ? 1'b0 : m_busy[r]);
      nt[r] = restore ? m_ckt[rid][r] : m_tag[r];
    end
    for (int k = 0; k < NCMT; k++)
      if (cmt_valid[k] && c_r(k) != 0 && c_t(k) == nt[c_r(k)]) nb[c_r(k)] = 0;
    for (int s = 0; s < NCKPT; s++)
      if (m_ckv[s])
        for (int k = 0; k < NCMT; k++)
          if (cmt_valid[k] && m_ckt[s][c_r(k)] == c_t(k)) m_ckb[s][c_r(k)] = 0;
    if (has_misbranch) begin
      for (int s = 0; s < NCKPT; s++) m_ckv[s] = 0;
    end else begin
      if (needsetbusy && rd_addr != 0) begin
        nb[rd_addr] = 1; nt[rd_addr] = int'(rd_rob_num);
      end
      if (ckpt_save) begin
        sid = int'(ckpt_save_id);
        m_ckv[sid] = 1;
        for (int r = 0; r < NREG; r++) begin
          m_ckb[sid][r] = nb[r]; m_ckt[sid][r] = nt[r];
        end
      end
    end
    m_data = nd; m_busy = nb; m_tag = nt;
  endtask

  task automatic idle();
    rdy = 1; needsetbusy = 0; rd_addr = '0; rd_rob_num = '0;
    cmt_valid = '0; cmt_reg = '0; cmt_data = '0; cmt_rob_num = '0;
    ckpt_save = 0; ckpt_save_id = '0; has_misbranch = 0;
    ckpt_restore_en = 0; ckpt_restore_id = '0;
  endtask

  task automatic set_cmt(input int k, input int r, input logic [XLEN-1:0] d,
                         input int t);
    cmt_valid[k] = 1'b1;
    cmt_reg[k*RAW +: RAW] = RAW'(r);
    cmt_data[k*XLEN +: XLEN] = d;
    cmt_rob_num[k*TAGW +: TAGW] = TAGW'(t);
  endtask

  task automatic rename(input int r, input int t);
    needsetbusy = 1; rd_addr = RAW'(r); rd_rob_num = TAGW'(t);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 0; model_reset();
    repeat (3) @(negedge clk);
    rst = 1;
    rs1_addr = 3; rs2_addr = 31; settle();
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b0 || rs1_rob_num !== 4'h0) begin
      n_err++; $display("FAIL reset_rs1: data=%h busy=%b tag=%h want 0/0/0", rs1_data, rs1_busy, rs1_rob_num); end
    n_cmp++; if (rs2_data !== 32'h0 || rs2_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_rs2: data=%h busy=%b want 0/0", rs2_data, rs2_busy); end
    n_cmp++; if (ckpt_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_ckpt_valid: got %b want 0000", ckpt_valid); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); rename(5, 3); tick();
    idle(); set_cmt(0, 5, 32'h55, 3); rs1_addr = 5; settle();
    n_cmp++; if (rs1_data !== 32'h55 || rs1_busy !== 1'b0 || rs1_rob_num !== 4'd3) begin
      n_err++; $display("FAIL bypass_same_cycle: data=%h busy=%b tag=%h want 55/0/3", rs1_data, rs1_busy, rs1_rob_num); end
    tick();
    idle(); rs1_addr = 5; settle();
    n_cmp++; if (rs1_data !== 32'h55 || rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL bypass_next_cycle: data=%h busy=%b want 55/0", rs1_data, rs1_busy); end
  endtask

  task automatic test_stale_commit();
    idle(); rename(5, 3); tick();
    idle(); rename(5, 7); rs2_addr = 5; settle();
    n_cmp++; if (rs2_busy !== 1'b1 || rs2_rob_num !== 4'd3) begin
      n_err++; $display("FAIL rename_not_visible: busy=%b tag=%h want 1/3", rs2_busy, rs2_rob_num); end
    tick();
    idle(); set_cmt(0, 5, 32'h11, 3); tick();
    idle(); rs1_addr = 5; settle();
    n_cmp++; if (rs1_data !== 32'h11 || rs1_busy !== 1'b1 || rs1_rob_num !== 4'd7) begin
      n_err++; $display("FAIL stale_commit: data=%h busy=%b tag=%h want 11/1/7", rs1_data, rs1_busy, rs1_rob_num); end
  endtask

  task automatic test_dual_commit();
    idle(); rename(6, 2); tick();
    idle(); set_cmt(0, 6, 32'hA, 1); set_cmt(1, 6, 32'hB, 2); rs1_addr = 6; settle();
    n_cmp++; if (rs1_data !== 32'hB || rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL dual_commit_bypass: data=%h busy=%b want b/0", rs1_data, rs1_busy); end
    tick();
    idle(); rs2_addr = 6; settle();
    n_cmp++; if (rs2_data !== 32'hB || rs2_busy !== 1'b0 || rs2_rob_num !== 4'd2) begin
      n_err++; $display("FAIL dual_commit_state: data=%h busy=%b tag=%h want b/0/2", rs2_data, rs2_busy, rs2_rob_num); end
  endtask

  task automatic test_ckpt_restore();
    idle(); rename(7, 4); tick();
    idle(); ckpt_save = 1; ckpt_save_id = 2; tick();
    idle(); settle();
    n_cmp++; if (ckpt_valid !== 4'b0100) begin
      n_err++; $display("FAIL ckpt_saved: got %b want 0100", ckpt_valid); end
    rename(7, 9); tick();
    idle(); set_cmt(1, 7, 32'h77, 4); tick();
    idle(); rs1_addr = 7; settle();
    n_cmp++; if (rs1_busy !== 1'b1 || rs1_rob_num !== 4'd9 || rs1_data !== 32'h77) begin
      n_err++; $display("FAIL ckpt_pre_restore: data=%h busy=%b tag=%h want 77/1/9", rs1_data, rs1_busy, rs1_rob_num); end
    has_misbranch = 1; ckpt_restore_en = 1; ckpt_restore_id = 2; tick();
    idle(); rs1_addr = 7; settle();
    n_cmp++; if (rs1_busy !== 1'b0 || rs1_rob_num !== 4'd4 || ckpt_valid !== 4'b0000) begin
      n_err++; $display("FAIL ckpt_restore: busy=%b tag=%h valid=%b want 0/4/0000", rs1_busy, rs1_rob_num, ckpt_valid); end
  endtask

  task automatic test_rdy_reset();
    idle(); set_cmt(0, 1, 32'h99, 0); tick();
    idle(); rename(1, 5); ckpt_save = 1; ckpt_save_id = 1; tick();
    idle(); rename(0, 6); rs2_addr = 0; tick();
    idle(); rs2_addr = 0; settle();
    n_cmp++; if (rs2_busy !== 1'b0 || rs2_rob_num !== 4'd0) begin
      n_err++; $display("FAIL rename_x0: busy=%b tag=%h want 0/0", rs2_busy, rs2_rob_num); end
    idle(); rdy = 0; has_misbranch = 1; rename(1, 2); set_cmt(0, 1, 32'h12, 7);
    ckpt_save = 1; ckpt_save_id = 3; tick(); tick();
    idle(); rdy = 0; rs1_addr = 1; settle();
    n_cmp++; if (rs1_data !== 32'h99 || rs1_busy !== 1'b1 || rs1_rob_num !== 4'd5 || ckpt_valid !== 4'b0010) begin
      n_err++; $display("FAIL rdy_freeze: data=%h busy=%b tag=%h valid=%b want 99/1/5/0010", rs1_data, rs1_busy, rs1_rob_num, ckpt_valid); end
    rst = 0; model_reset(); settle();
    n_cmp++; if (rs1_data !== 32'h0 || rs1_busy !== 1'b0 || rs1_rob_num !== 4'd0 || ckpt_valid !== 4'b0000) begin
      n_err++; $display("FAIL async_reset: data=%h busy=%b tag=%h valid=%b want 0/0/0/0000", rs1_data, rs1_busy, rs1_rob_num, ckpt_valid); end
    @(negedge clk);
    rst = 1; idle();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed1, ed2;
    bit eb1, eb2;
    int et1, et2, r;
    logic [NCKPT-1:0] ev;
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy = ($urandom % 10) != 0;
      for (int k = 0; k < NCMT; k++)
        if ($urandom % 2 == 1) begin
          r = int'($urandom % 8);
          set_cmt(k, r, $urandom, ($urandom % 2 == 1) ? m_tag[r] : int'($urandom % 16));
        end
      if ($urandom % 2 == 1) rename(int'($urandom % 8), int'($urandom % 16));
      if ($urandom % 6 == 0) begin
        ckpt_save = 1; ckpt_save_id = CKW'($urandom);
      end
      if ($urandom % 10 == 0) begin
        has_misbranch = 1; ckpt_restore_en = ($urandom % 4) != 0;
        ckpt_restore_id = CKW'($urandom);
      end
      rs1_addr = RAW'($urandom % 8);
      rs2_addr = RAW'($urandom);
      settle();
      model_read(int'(rs1_addr), ed1, eb1, et1);
      model_read(int'(rs2_addr), ed2, eb2, et2);
      for (int s = 0; s < NCKPT; s++) ev[s] = m_ckv[s];
      n_cmp++; if (rs1_data !== ed1 || rs1_busy !== eb1 || rs1_rob_num !== TAGW'(et1)) begin
        n_err++; $display("FAIL rand_rs1 n=%0d x%0d: got %h/%b/%h want %h/%b/%h", n, rs1_addr, rs1_data, rs1_busy, rs1_rob_num, ed1, eb1, et1); end
      n_cmp++; if (rs2_data !== ed2 || rs2_busy !== eb2 || rs2_rob_num !== TAGW'(et2)) begin
        n_err++; $display("FAIL rand_rs2 n=%0d x%0d: got %h/%b/%h want %h/%b/%h", n, rs2_addr, rs2_data, rs2_busy, rs2_rob_num, ed2, eb2, et2); end
      n_cmp++; if (ckpt_valid !== ev) begin
        n_err++; $display("FAIL rand_ckpt_valid n=%0d: got %b want %b", n, ckpt_valid, ev); end
      tick();
    end
  endtask

  initial begin
    idle(); rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_bypass();
    test_stale_commit();
    test_dual_commit();
    test_ckpt_restore();
    test_rdy_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
